// File: rtl/dot_stream_feeder.sv
// dot_stream_feeder: packs a serial (x,y) operand stream into 8-lane FP32
// vectors for the dot-product datapath, issues them under credit control,
// and buffers returned results in a first-word fall-through FIFO.
module dot_stream_feeder #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [31:0]     s_x,
    input  logic [31:0]     s_y,
    input  logic            s_last,
    output logic            dp_ready,
    output logic [255:0]    dp_x,
    output logic [255:0]    dp_y,
    input  logic            dp_vld,
    input  logic [31:0]     dp_z,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [31:0]     m_z,
    output logic [CW-1:0]   vec_cnt,
    output logic            err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0][31:0]  stage_x_q, stage_x_d;
    logic [7:0][31:0]  stage_y_q, stage_y_d;
    logic [255:0]      dp_x_q;
    logic [255:0]      dp_y_q;
    logic              dp_ready_q;
    logic [AW:0]       outst_q, outst_d;
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic [31:0]       mem_q [DEPTH];
    logic [CW-1:0]     vec_cnt_q;
    logic              err_q;

    logic              accept;
    logic              completing;
    logic [AW:0]       fifo_count;
    logic [AW+1:0]     credit_sum;
    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    // Handshake, credit and FIFO bookkeeping terms shared by both processes
    always_comb begin
        accept     = (state_q == COLLECT) && s_valid;
        completing = accept && ((idx_q == 3'd7) || s_last);
        fifo_count = wr_ptr_q - rd_ptr_q;
        credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
        credit_ok  = credit_sum < (AW+2)'(DEPTH);
        issue      = (state_q == FULL) && credit_ok;
        push       = dp_vld && (outst_q != '0);
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        pop        = !fifo_empty && m_ready;
    end

    // Next-state logic: lane staging, zero padding on completion, handoff
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stage_x_d = stage_x_q;
        stage_y_d = stage_y_q;
        outst_d   = outst_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    stage_x_d[idx_q] = s_x;
                    stage_y_d[idx_q] = s_y;
                    if (completing) begin
                        for (int i = 0; i < 8; i++) begin
                            if (3'(i) > idx_q) begin
                                stage_x_d[i] = '0;
                                stage_y_d[i] = '0;
                            end
                        end
                        idx_d   = '0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            FULL: begin
                if (issue) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
        case ({issue, push})
            2'b10:   outst_d = outst_q + (AW+1)'(1);
            2'b01:   outst_d = outst_q - (AW+1)'(1);
            default: outst_d = outst_q;
        endcase
    end

    // Control, staging, issue registers and FIFO pointers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= COLLECT;
            idx_q      <= '0;
            stage_x_q  <= '0;
            stage_y_q  <= '0;
            dp_x_q     <= '0;
            dp_y_q     <= '0;
            dp_ready_q <= 1'b0;
            outst_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            vec_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            stage_x_q  <= stage_x_d;
            stage_y_q  <= stage_y_d;
            dp_ready_q <= issue;
            outst_q    <= outst_d;
            if (issue) begin
                dp_x_q    <= stage_x_q;
                dp_y_q    <= stage_y_q;
                vec_cnt_q <= vec_cnt_q + CW'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            if (dp_vld && (outst_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Result storage; contents are meaningless while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= dp_z;
        end
    end

    assign s_ready  = (state_q == COLLECT);
    assign dp_ready = dp_ready_q;
    assign dp_x     = dp_x_q;
    assign dp_y     = dp_y_q;
    assign m_valid  = !fifo_empty;
    assign m_z      = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[AW-1:0]];
    assign vec_cnt  = vec_cnt_q;
    assign err      = err_q;

endmodule

// File: tb/tb_dot_stream_feeder.sv
// Directed bench for dot_stream_feeder with a 10-stage FP32 datapath model.
module tb_dot_stream_feeder;

    localparam int CW = 16;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F5  = 32'h40A00000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F8  = 32'h41000000;
    localparam logic [31:0] F9  = 32'h41100000;
    localparam logic [31:0] F16 = 32'h41800000;
    localparam logic [31:0] F24 = 32'h41C00000;
    localparam logic [31:0] F32 = 32'h42000000;
    localparam logic [31:0] F40 = 32'h42200000;
    localparam logic [31:0] F48 = 32'h42400000;

    logic          clk = 1'b0;
    logic          rst;
    logic          sValid;
    logic          sReady;
    logic [31:0]   sX;
    logic [31:0]   sY;
    logic          sLast;
    logic          dpReady;
    logic [255:0]  dpX;
    logic [255:0]  dpY;
    logic          dpVld;
    logic [31:0]   dpZ;
    logic          mValid;
    logic          mReady;
    logic [31:0]   mZ;
    logic [CW-1:0] vecCnt;
    logic          err;

    logic          spurVld;
    logic [9:0]    pipeV;
    logic [31:0]   pipeZ [10];

    int            vectors = 0;
    int            miscompares = 0;
    int            cyc = 0;
    int            lowCnt = 0;
    int            dblReady = 0;
    logic          prevReady = 1'b0;
    int            pulseCyc[$];
    logic [31:0]   gotZ[$];

    dot_stream_feeder #(.DEPTH(4), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (sValid),
        .s_ready  (sReady),
        .s_x      (sX),
        .s_y      (sY),
        .s_last   (sLast),
        .dp_ready (dpReady),
        .dp_x     (dpX),
        .dp_y     (dpY),
        .dp_vld   (dpVld),
        .dp_z     (dpZ),
        .m_valid  (mValid),
        .m_ready  (mReady),
        .m_z      (mZ),
        .vec_cnt  (vecCnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        logic [10:0] e;
        if (b[30:0] == 31'h0) return 0.0;
        e = {3'b000, b[30:23]} + 11'd896;
        return $bitstoreal({b[31], e, b[22:0], 29'h0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return 32'h0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] dotProduct(input logic [255:0] x, input logic [255:0] y);
        real acc;
        acc = 0.0;
        for (int i = 0; i < 8; i++) begin
            acc = acc + f2r(x[32*i +: 32]) * f2r(y[32*i +: 32]);
        end
        return r2f(acc);
    endfunction

    // Datapath model: fixed 10-cycle in-order pipeline, cleared by the shared reset
    always @(posedge clk) begin
        if (rst) begin
            pipeV <= '0;
        end else begin
            pipeV    <= {pipeV[8:0], dpReady};
            pipeZ[0] <= dotProduct(dpX, dpY);
            for (int i = 1; i < 10; i++) begin
                pipeZ[i] <= pipeZ[i-1];
            end
        end
    end

    assign dpVld = pipeV[9] | spurVld;
    assign dpZ   = spurVld ? 32'hDEADBEEF : pipeZ[9];

    // Monitor: cycle count, issue pulse times, stalls, consumed results
    always @(posedge clk) begin
        cyc <= cyc + 1;
        prevReady <= dpReady;
        if (!rst) begin
            if (dpReady) pulseCyc.push_back(cyc);
            if (dpReady && prevReady) dblReady <= dblReady + 1;
            if (sValid && !sReady) lowCnt <= lowCnt + 1;
            if (mValid && mReady) gotZ.push_back(mZ);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Offers one pair and holds it until accepted; s_valid is left high
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic last);
        int guard;
        guard  = 0;
        sValid = 1'b1;
        sX     = x;
        sY     = y;
        sLast  = last;
        while (!sReady && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) checkOutput("accept_timeout", 32'(guard), 32'd0);
        tick();
    endtask

    task automatic applyVector(input logic [31:0] x, input logic [31:0] y, input int n, input logic withLast);
        for (int i = 0; i < n; i++) begin
            applyStimulus(x, y, withLast && (i == n - 1));
        end
    endtask

    task automatic waitResults(input int n);
        int guard;
        guard = 0;
        while (gotZ.size() < n && guard < 300) begin
            tick();
            guard++;
        end
        checkOutput("results_arrived", 32'(gotZ.size() >= n), 32'd1);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_dp_ready"}, 32'(dpReady), 32'd0);
        checkOutput({tag, "_dp_x_zero"}, 32'(dpX != '0), 32'd0);
        checkOutput({tag, "_dp_y_zero"}, 32'(dpY != '0), 32'd0);
        checkOutput({tag, "_m_valid"}, 32'(mValid), 32'd0);
        checkOutput({tag, "_m_z"}, mZ, 32'h0);
        checkOutput({tag, "_vec_cnt"}, 32'(vecCnt), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        checkOutput({tag, "_s_ready"}, 32'(sReady), 32'd1);
    endtask

    initial begin
        int base;
        int lowBase;
        logic [31:0] expZ [6];
        logic [31:0] yv [6];

        rst = 1'b1; sValid = 1'b0; sX = '0; sY = '0; sLast = 1'b0;
        mReady = 1'b0; spurVld = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checkResetState("reset");

        // Single full vector 1.0 x 2.0
        mReady = 1'b1;
        applyVector(F1, F2, 8, 1'b1);
        sValid = 1'b0;
        checkOutput("full_s_ready_low", 32'(sReady), 32'd0);
        tick();
        checkOutput("full_dp_ready", 32'(dpReady), 32'd1);
        checkOutput("full_vec_cnt", 32'(vecCnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("full_x_lane%0d", i), dpX[32*i +: 32], F1);
            checkOutput($sformatf("full_y_lane%0d", i), dpY[32*i +: 32], F2);
        end
        tick();
        checkOutput("full_dp_ready_one_cycle", 32'(dpReady), 32'd0);
        checkOutput("full_s_ready_back", 32'(sReady), 32'd1);
        waitResults(1);
        checkOutput("full_result", gotZ[0], F16);

        // Short vector: three pairs, lanes 3..7 must be zero padded
        gotZ.delete();
        applyVector(F1, F3, 3, 1'b1);
        sValid = 1'b0;
        tick();
        checkOutput("short_dp_ready", 32'(dpReady), 32'd1);
        checkOutput("short_vec_cnt", 32'(vecCnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("short_x_lane%0d", i), dpX[32*i +: 32], (i < 3) ? F1 : 32'h0);
            checkOutput($sformatf("short_y_lane%0d", i), dpY[32*i +: 32], (i < 3) ? F3 : 32'h0);
        end
        tick();
        checkOutput("short_x_held", dpX[31:0], F1);
        waitResults(1);
        checkOutput("short_result", gotZ[0], F9);

        // Spurious datapath result with nothing outstanding
        spurVld = 1'b1;
        tick();
        spurVld = 1'b0;
        tick();
        checkOutput("spur_err", 32'(err), 32'd1);
        checkOutput("spur_m_valid", 32'(mValid), 32'd0);
        tick();
        checkOutput("spur_m_valid_later", 32'(mValid), 32'd0);

        // Back-pressure: only DEPTH vectors may be in flight or buffered
        yv[0] = F1; yv[1] = F2; yv[2] = F3; yv[3] = F4; yv[4] = F5; yv[5] = F6;
        expZ[0] = F8; expZ[1] = F16; expZ[2] = F24; expZ[3] = F32; expZ[4] = F40; expZ[5] = F48;
        gotZ.delete();
        mReady = 1'b0;
        base = pulseCyc.size();
        for (int v = 0; v < 5; v++) begin
            applyVector(F1, yv[v], 8, 1'b1);
        end
        sValid = 1'b0;
        repeat (40) tick();
        checkOutput("bp_pulses_stalled", 32'(pulseCyc.size() - base), 32'd4);
        checkOutput("bp_s_ready_low", 32'(sReady), 32'd0);
        checkOutput("bp_m_valid", 32'(mValid), 32'd1);
        checkOutput("bp_head", mZ, F8);
        repeat (3) tick();
        checkOutput("bp_head_stable", mZ, F8);
        checkOutput("bp_nothing_consumed", 32'(gotZ.size()), 32'd0);
        checkOutput("bp_err_sticky", 32'(err), 32'd1);
        mReady = 1'b1;
        applyVector(F1, yv[5], 8, 1'b1);
        sValid = 1'b0;
        waitResults(6);
        for (int v = 0; v < 6; v++) begin
            if (v < gotZ.size()) checkOutput($sformatf("bp_result%0d", v), gotZ[v], expZ[v]);
        end
        checkOutput("bp_pulses_total", 32'(pulseCyc.size() - base), 32'd6);
        checkOutput("bp_vec_cnt", 32'(vecCnt), 32'd8);

        // Streaming at rate: four back-to-back vectors
        gotZ.delete();
        base = pulseCyc.size();
        lowBase = lowCnt;
        for (int v = 0; v < 4; v++) begin
            applyVector(F1, yv[v], 8, 1'b1);
        end
        sValid = 1'b0;
        waitResults(4);
        for (int v = 0; v < 4; v++) begin
            if (v < gotZ.size()) checkOutput($sformatf("stream_result%0d", v), gotZ[v], expZ[v]);
        end
        checkOutput("stream_pulses", 32'(pulseCyc.size() - base), 32'd4);
        for (int k = 0; k < 3; k++) begin
            if (base + k + 1 < pulseCyc.size())
                checkOutput($sformatf("stream_interval%0d", k),
                            32'(pulseCyc[base+k+1] - pulseCyc[base+k]), 32'd9);
        end
        checkOutput("stream_stall_cycles", 32'(lowCnt - lowBase), 32'd3);

        // Reset mid-vector with a buffered result and a partial vector pending
        gotZ.delete();
        mReady = 1'b0;
        applyVector(F1, F5, 1, 1'b1);
        sValid = 1'b0;
        repeat (15) tick();
        checkOutput("pre_reset_m_valid", 32'(mValid), 32'd1);
        checkOutput("pre_reset_head", mZ, F5);
        applyVector(F2, F2, 5, 1'b0);
        sValid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkResetState("midreset");
        mReady = 1'b1;
        applyVector(F1, F1, 8, 1'b1);
        sValid = 1'b0;
        tick();
        checkOutput("post_reset_dp_ready", 32'(dpReady), 32'd1);
        checkOutput("post_reset_vec_cnt", 32'(vecCnt), 32'd1);
        checkOutput("post_reset_x_lane7", dpX[255:224], F1);
        waitResults(1);
        repeat (20) tick();
        checkOutput("post_reset_count", 32'(gotZ.size()), 32'd1);
        if (gotZ.size() > 0) checkOutput("post_reset_result", gotZ[0], F8);
        checkOutput("post_reset_err", 32'(err), 32'd0);

        checkOutput("dp_ready_single_cycle", 32'(dblReady), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
